// File: rtl/ps2_host_rx_fifo.sv
// PS/2 host receiver: synchronise + debounce pins, deframe 11-bit frames, queue {frame_err, parity_err, code} in a FWFT FIFO.
// Optional mid-frame inactivity watchdog is enabled by defining PS2_RX_TIMEOUT_EN.
module ps2_host_rx_fifo #(
  parameter int DEBOUNCE_CYCLES = 8,
  parameter int FIFO_DEPTH      = 8,
  parameter int TIMEOUT_CYCLES  = 100000
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic                         i_ps2_clk,
  input  logic                         i_ps2_data,
  output logic                         o_rx_valid,
  input  logic                         i_rx_ready,
  output logic [7:0]                   o_rx_data,
  output logic                         o_rx_parity_err,
  output logic                         o_rx_frame_err,
  output logic [$clog2(FIFO_DEPTH):0]  o_fifo_level,
  output logic                         o_overflow,
  output logic                         o_timeout_err,
  output logic                         o_busy
);

  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int DBW = $clog2(DEBOUNCE_CYCLES + 1);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] DATA   = 2'd1;
  localparam logic [1:0] PARITY = 2'd2;
  localparam logic [1:0] STOP   = 2'd3;

  // Bit 0 carries the PS/2 clock, bit 1 the PS/2 data.
  logic [1:0]     r_meta;
  logic [1:0]     r_sync;
  logic [1:0]     r_deb;
  logic [DBW-1:0] r_dbCnt [2];
  logic           r_clkPrev;

  logic [1:0]     r_state;
  logic [2:0]     r_bitCnt;
  logic [7:0]     r_shReg;
  logic           r_parity;
  logic           r_timeoutErr;
  logic           r_overflow;

  logic [9:0]     r_mem [FIFO_DEPTH];
  logic [AW:0]    r_wrPtr;
  logic [AW:0]    r_rdPtr;

  logic           w_fall;
  logic           w_dataBit;
  logic           w_timeout;
  logic           w_push;
  logic [9:0]     w_entry;
  logic           w_empty;
  logic           w_full;
  logic           w_pop;
  logic           w_wrEn;
  logic [9:0]     w_head;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_meta    <= 2'b11;
      r_sync    <= 2'b11;
      r_deb     <= 2'b11;
      r_clkPrev <= 1'b1;
      for (int i = 0; i < 2; i++) r_dbCnt[i] <= '0;
    end else begin
      r_meta    <= {i_ps2_data, i_ps2_clk};
      r_sync    <= r_meta;
      r_clkPrev <= r_deb[0];
      for (int i = 0; i < 2; i++) begin
        if (r_sync[i] == r_deb[i]) begin
          r_dbCnt[i] <= '0;
        end else if (r_dbCnt[i] == DBW'(DEBOUNCE_CYCLES - 1)) begin
          r_deb[i]   <= r_sync[i];
          r_dbCnt[i] <= '0;
        end else begin
          r_dbCnt[i] <= r_dbCnt[i] + DBW'(1);
        end
      end
    end
  end

  assign w_fall    = r_clkPrev & ~r_deb[0];
  assign w_dataBit = r_deb[1];

`ifdef PS2_RX_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] r_toCnt;

  // Saturates at the limit; a fall in the same cycle wins over the abort.
  always_ff @(posedge i_clk) begin
    if (i_rst || r_state == IDLE || w_fall) begin
      r_toCnt <= '0;
    end else if (r_toCnt != TW'(TIMEOUT_CYCLES)) begin
      r_toCnt <= r_toCnt + TW'(1);
    end
  end

  assign w_timeout = (r_state != IDLE) && !w_fall && (r_toCnt == TW'(TIMEOUT_CYCLES));
`else
  assign w_timeout = 1'b0;
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst || w_timeout) begin
      r_state  <= IDLE;
      r_bitCnt <= '0;
      r_shReg  <= '0;
      r_parity <= 1'b0;
    end else if (w_fall) begin
      case (r_state)
        IDLE: begin
          if (!w_dataBit) begin
            r_state  <= DATA;
            r_bitCnt <= '0;
          end
        end
        DATA: begin
          r_shReg  <= {w_dataBit, r_shReg[7:1]};
          r_bitCnt <= r_bitCnt + 3'd1;
          if (r_bitCnt == 3'd7) r_state <= PARITY;
        end
        PARITY: begin
          r_parity <= w_dataBit;
          r_state  <= STOP;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign w_push  = w_fall && (r_state == STOP);
  assign w_entry = {~w_dataBit, ~(^r_shReg ^ r_parity), r_shReg};

  assign w_empty = (r_wrPtr == r_rdPtr);
  assign w_full  = ((r_wrPtr ^ r_rdPtr) == {1'b1, {AW{1'b0}}});
  assign w_pop   = ~w_empty & i_rx_ready;
  assign w_wrEn  = w_push & (~w_full | w_pop);

  always_ff @(posedge i_clk) begin
    if (w_wrEn) r_mem[r_wrPtr[AW-1:0]] <= w_entry;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wrPtr      <= '0;
      r_rdPtr      <= '0;
      r_overflow   <= 1'b0;
      r_timeoutErr <= 1'b0;
    end else begin
      if (w_wrEn) r_wrPtr <= r_wrPtr + 1'b1;
      if (w_pop)  r_rdPtr <= r_rdPtr + 1'b1;
      r_overflow   <= w_push & w_full & ~w_pop;
      r_timeoutErr <= w_timeout;
    end
  end

  assign w_head          = r_mem[r_rdPtr[AW-1:0]];
  assign o_rx_valid      = ~w_empty;
  assign o_rx_data       = w_empty ? 8'h00 : w_head[7:0];
  assign o_rx_parity_err = w_empty ? 1'b0 : w_head[8];
  assign o_rx_frame_err  = w_empty ? 1'b0 : w_head[9];
  assign o_fifo_level    = r_wrPtr - r_rdPtr;
  assign o_overflow      = r_overflow;
  assign o_timeout_err   = r_timeoutErr;
  assign o_busy          = (r_state != IDLE);

endmodule

// File: tb/tb_ps2_host_rx_fifo.sv
// Directed bench for ps2_host_rx_fifo: clean, parity/stop faults, overflow, glitch, timeout (PS2_RX_TIMEOUT_EN) and reset mid-frame.
module tb_ps2_host_rx_fifo;

  localparam int DEB   = 4;
  localparam int DEPTH = 8;
  localparam int TMO   = 300;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ps2Clk = 1'b1;
  logic       ps2Data = 1'b1;
  logic       rxReady = 1'b0;
  logic       rxValid;
  logic [7:0] rxData;
  logic       parityErr;
  logic       frameErr;
  logic [3:0] fifoLevel;
  logic       overflow;
  logic       timeoutErr;
  logic       busy;

  int testsRun = 0;
  int failCount = 0;
  int validCycles = 0;
  int ovfCount = 0;
  int toCount = 0;
  logic [9:0] popQ[$];

  ps2_host_rx_fifo #(
    .DEBOUNCE_CYCLES(DEB),
    .FIFO_DEPTH(DEPTH),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .i_ps2_clk(ps2Clk),
    .i_ps2_data(ps2Data),
    .o_rx_valid(rxValid),
    .i_rx_ready(rxReady),
    .o_rx_data(rxData),
    .o_rx_parity_err(parityErr),
    .o_rx_frame_err(frameErr),
    .o_fifo_level(fifoLevel),
    .o_overflow(overflow),
    .o_timeout_err(timeoutErr),
    .o_busy(busy)
  );

  always #5 clk = ~clk;

  // Inputs move just after posedge, so the negedge sample sees exactly what the next edge will act on.
  always @(negedge clk) begin
    if (!rst) begin
      if (rxValid && rxReady) popQ.push_back({frameErr, parityErr, rxData});
      if (rxValid) validCycles++;
      if (overflow) ovfCount++;
      if (timeoutErr) toCount++;
    end
  end

  task automatic waitCycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testsRun++;
    assert (observed === expected)
    else begin
      failCount++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic sendBits(input logic [10:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      ps2Data = bits[i];
      waitCycles(6);
      ps2Clk = 1'b0;
      waitCycles(12);
      ps2Clk = 1'b1;
      waitCycles(6);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] code, input logic flipParity, input logic stopBit);
    logic par;
    par = ~(^code) ^ flipParity;
    sendBits({stopBit, par, code, 1'b0}, 11);
    ps2Data = 1'b1;
    waitCycles(10);
  endtask

  task automatic checkPop(input string tag, input logic [9:0] expected);
    logic [31:0] got;
    got = (popQ.size() > 0) ? {22'd0, popQ.pop_front()} : 32'hFFFF;
    checkOutput(tag, got, {22'd0, expected});
  endtask

  initial begin
    waitCycles(4);
    checkOutput("rst_valid", rxValid, 1'b0);
    checkOutput("rst_data", rxData, 8'h00);
    checkOutput("rst_perr", parityErr, 1'b0);
    checkOutput("rst_ferr", frameErr, 1'b0);
    checkOutput("rst_level", fifoLevel, 4'd0);
    checkOutput("rst_ovf", overflow, 1'b0);
    checkOutput("rst_tmo", timeoutErr, 1'b0);
    checkOutput("rst_busy", busy, 1'b0);
    rst = 1'b0;
    waitCycles(4);

    rxReady = 1'b1;
    popQ.delete();
    validCycles = 0;
    applyStimulus(8'h1C, 1'b0, 1'b1);
    checkOutput("clean_pops", popQ.size(), 1);
    checkPop("clean_entry", 10'h01C);
    checkOutput("clean_valid_cycles", validCycles, 1);
    checkOutput("clean_level", fifoLevel, 4'd0);

    applyStimulus(8'h1C, 1'b1, 1'b1);
    checkPop("parity_entry", 10'h11C);

    applyStimulus(8'hF0, 1'b0, 1'b0);
    checkPop("stop_entry", 10'h2F0);
    checkOutput("stop_level", fifoLevel, 4'd0);

    rxReady = 1'b0;
    popQ.delete();
    ovfCount = 0;
    for (int c = 1; c <= 9; c++) begin
      applyStimulus(8'(c), 1'b0, 1'b1);
      if (c == 8) checkOutput("ovf_none_yet", ovfCount, 0);
    end
    checkOutput("ovf_level", fifoLevel, 4'd8);
    checkOutput("ovf_pulses", ovfCount, 1);
    checkOutput("ovf_hold_valid", rxValid, 1'b1);
    checkOutput("ovf_hold_data", rxData, 8'h01);
    rxReady = 1'b1;
    waitCycles(12);
    checkOutput("drain_pops", popQ.size(), 8);
    for (int c = 1; c <= 8; c++) checkPop($sformatf("drain_%0d", c), 10'(c));
    checkOutput("drain_level", fifoLevel, 4'd0);
    checkOutput("drain_valid", rxValid, 1'b0);

    popQ.delete();
    ps2Data = 1'b0;
    waitCycles(10);
    ps2Clk = 1'b0;
    waitCycles(DEB - 1);
    ps2Clk = 1'b1;
    waitCycles(20);
    checkOutput("glitch_busy", busy, 1'b0);
    ps2Data = 1'b1;
    waitCycles(10);
    applyStimulus(8'h1C, 1'b0, 1'b1);
    checkPop("glitch_next", 10'h01C);

    toCount = 0;
    sendBits({7'h7F, 3'b101, 1'b0}, 4);
    ps2Data = 1'b1;
    checkOutput("partial_busy", busy, 1'b1);
    waitCycles(TMO + 100);
`ifdef PS2_RX_TIMEOUT_EN
    checkOutput("tmo_pulses", toCount, 1);
    checkOutput("tmo_busy", busy, 1'b0);
    checkOutput("tmo_level", fifoLevel, 4'd0);
    checkOutput("tmo_nopush", popQ.size(), 0);
    applyStimulus(8'h1C, 1'b0, 1'b1);
    checkPop("tmo_next", 10'h01C);
`else
    checkOutput("stall_pulses", toCount, 0);
    checkOutput("stall_busy", busy, 1'b1);
    rst = 1'b1;
    waitCycles(2);
    rst = 1'b0;
    waitCycles(2);
    checkOutput("stall_rst_busy", busy, 1'b0);
`endif

    rxReady = 1'b0;
    popQ.delete();
    applyStimulus(8'h11, 1'b0, 1'b1);
    applyStimulus(8'h22, 1'b0, 1'b1);
    checkOutput("mid_level2", fifoLevel, 4'd2);
    sendBits({6'h3F, 4'b1010, 1'b0}, 5);
    ps2Data = 1'b1;
    checkOutput("mid_busy", busy, 1'b1);
    rst = 1'b1;
    waitCycles(2);
    rst = 1'b0;
    waitCycles(2);
    checkOutput("mid_level", fifoLevel, 4'd0);
    checkOutput("mid_valid", rxValid, 1'b0);
    checkOutput("mid_busy0", busy, 1'b0);
    rxReady = 1'b1;
    applyStimulus(8'h1C, 1'b0, 1'b1);
    checkOutput("mid_next_pops", popQ.size(), 1);
    checkPop("mid_next", 10'h01C);

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule

// File: doc/ps2_host_rx_fifo.md
# ps2_host_rx_fifo

Parametrised PS/2 host receiver that samples device-to-host frames on ps2_clk falling edges, checks odd parity and the stop bit, and queues each frame with its error flags in a first-word-fall-through FIFO. A ready/valid output port drains the FIFO. This block is the receive front end between the raw PS/2 pins and the scan-code decoder. Compared with the single-register receiver, it adds a configurable debounce length, output buffering with overflow reporting, and an optional inactivity watchdog.

## Interface
- DEBOUNCE_CYCLES, 8, number of consecutive clk cycles a synchronised input must differ from the debounced value before the debounced value changes; must be at least 1.
- FIFO_DEPTH, 8, number of frame entries; must be a power of 2 and at least 2.
- TIMEOUT_CYCLES, 100000, idle clk cycles allowed mid-frame before the partial frame is aborted; only used when PS2_RX_TIMEOUT_EN is defined.

- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- ps2_clk  in  1  raw PS/2 clock pin, asynchronous to clk.
- ps2_data  in  1  raw PS/2 data pin, asynchronous to clk.
- rx_valid  out  1  FIFO head is valid.
- rx_ready  in  1  consumer accepts the head; a pop happens when rx_valid and rx_ready are both 1.
- rx_data  out  8  scan code at the FIFO head.
- rx_parity_err  out  1  parity error flag of the head entry.
- rx_frame_err  out  1  stop-bit error flag of the head entry.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  number of stored entries.
- overflow  out  1  one-cycle pulse when a completed frame is dropped because the FIFO is full.
- timeout_err  out  1  one-cycle pulse when a partial frame is aborted.
- busy  out  1  receiver state is not IDLE.

## Operation
- Input path: each pin goes through a 2-flop synchroniser and then a debouncer.
  - The debounce counter resets whenever the synchronised value equals the debounced value.
  - The debounced value flips on the DEBOUNCE_CYCLES-th consecutive differing cycle.
  - Debounced values reset to 1.
- Edge detect: fall is the registered debounced clock being 1 while the current debounced clock is 0. It is combinational and lasts one cycle.
- FSM. All transitions happen only on fall; the data value used is the debounced data in the same cycle.
  - IDLE: data=0 moves to DATA with the bit counter at 0. data=1 stays in IDLE (spurious edge ignored).
  - DATA: the bit is shifted in LSB first, filling {data, shreg[7:1]}. After bit 7, move to PARITY.
  - PARITY: capture the parity bit, then move to STOP.
  - STOP: build the entry and push it. parity_err = ~(^shreg ^ parity), i.e. odd parity is required. frame_err = ~data. Return to IDLE.
- Entries with errors are still pushed; the consumer decides whether to discard them.
- FIFO:
  - Entry format is {frame_err, parity_err, code}.
  - Read and write pointers are $clog2(FIFO_DEPTH)+1 bits wide and wrap naturally.
  - full means the pointers differ only in the MSB.
  - Push when full and no pop in the same cycle: the entry is dropped, overflow pulses, and FIFO contents are unchanged.
  - Push when full with a pop in the same cycle: the push is accepted and overflow stays 0.
  - Push and pop in the same cycle: fifo_level is unchanged.
  - Empty FIFO: rx_valid=0 and rx_data, rx_parity_err, rx_frame_err are 0.
- Reset mid-frame: the partial frame is discarded, the FIFO is emptied, and the FSM returns to IDLE.

## Timing
- Reset values:
  - rx_valid, rx_data, rx_parity_err, rx_frame_err, overflow, timeout_err and busy are all 0.
  - fifo_level is 0.
  - Debounced clock and data are 1. The FSM is in IDLE.
- Pin-to-fall latency: DEBOUNCE_CYCLES+3 clk cycles, given the pin is stable from the cycle it changes.
- The push happens in the fall cycle of the stop bit. rx_valid, fifo_level and overflow update on the next clk edge.
- A pop on a clk edge exposes the next entry, or rx_valid=0, immediately after that edge.
- rx_data and the error flags must hold while rx_valid=1 and rx_ready=0.
- timeout_err and busy are registered.

## Configuration
- PS2_RX_TIMEOUT_EN defined:
  - A counter runs while the FSM is not IDLE. It clears on every fall and while in IDLE.
  - When the counter reaches TIMEOUT_CYCLES, the FSM returns to IDLE, the shift register is discarded, nothing is pushed, and timeout_err pulses for one cycle.
  - If a fall coincides with the timeout, the fall takes priority.
- PS2_RX_TIMEOUT_EN undefined: there is no counter, the timeout_err port remains and is tied to 0, and a stalled frame waits indefinitely.

## Test plan
- Clean frame: start, 0x1C LSB first, parity 0, stop 1, with rx_ready=1. Expect rx_valid high for exactly one cycle with rx_data=0x1C, both error flags 0 and fifo_level returning to 0.
- Parity fault: the same frame with parity 1. Expect rx_data=0x1C, rx_parity_err=1 and rx_frame_err=0.
- Stop fault: 0xF0 with parity 1 and stop 0. Expect rx_data=0xF0, rx_frame_err=1 and rx_parity_err=0.
- Overflow: rx_ready=0, send FIFO_DEPTH+1 frames 0x01 through 0x09 (DEPTH=8).
  - Expect fifo_level=8 and a single overflow pulse on the 9th frame.
  - Then raise rx_ready and expect the drain order 0x01 through 0x08.
- Glitch and timeout (macro defined):
  - A ps2_clk low pulse of DEBOUNCE_CYCLES-1 cycles produces no state change.
  - Start bit plus 3 data bits followed by TIMEOUT_CYCLES of idle produces one timeout_err pulse, busy=0, and nothing pushed. A following 0x1C frame is then received correctly.
- Reset mid-frame: assert rst after 4 data bits with 2 entries queued. Expect fifo_level=0, rx_valid=0 and busy=0, and the next frame received correctly.
